wash_plant_timer: RTL and testbench
===================================

Name: wash_plant_timer

Overview:
- Upstream event generator for the washing-machine controller FSM.
- Debounces the raw door switch into door_close.
- Models drum water level from the FSM's fill and drain valve commands, and produces the filled and drained pulses.
- Times the wash and spin phases from motor and valve commands, and produces the cycleTO and spinTO pulses.
- All event outputs are single-cycle pulses, matching what the controller consumes.

Parameters:
DEBOUNCE_CYC, 4, consecutive stable synchronised samples required before door_close changes
LEVEL_MAX, 8, level count at which the drum is full
WASH_CYC, 16, qualifying motor cycles per wash phase before cycleTO
SPIN_CYC, 8, qualifying motor cycles per spin phase before spinTO
CNT_W, 16, timer counter width; WASH_CYC and SPIN_CYC must each be < 2**CNT_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-low reset (0 = reset), sampled on rising clk
door_sw_raw  input  1  asynchronous raw door switch, 1 = closed
fill_val_on  input  1  fill valve command from controller
drain_val_on  input  1  drain valve command from controller
motor_on  input  1  motor command from controller
door_close  output  1  debounced door state
filled  output  1  one-cycle pulse, drum reached LEVEL_MAX
drained  output  1  one-cycle pulse, drum reached empty under drain
cycleTO  output  1  one-cycle pulse, wash phase elapsed
spinTO  output  1  one-cycle pulse, spin phase elapsed
water_level  output  LVL_W  current level; LVL_W = $clog2(LEVEL_MAX+1)

Behaviour:
- Reset (reset=0 at a rising edge): all outputs, counters, synchronisers and arm flags go to 0. Reset mid-operation aborts any phase; no pulse is issued for the aborted phase.
- Door debounce:
  - Two-flop synchroniser on door_sw_raw.
  - A stability counter clears whenever the synchronised value differs from door_close.
  - door_close takes the synchronised value on the edge at which that value has differed for DEBOUNCE_CYC consecutive cycles.
  - Glitches shorter than DEBOUNCE_CYC never propagate.
- Level model, evaluated every cycle:
  - fill only and level < LEVEL_MAX: level +1.
  - drain only and level > 0: level −1.
  - Both valves, neither valve, or saturated: hold. No wrap in either direction.
- filled:
  - Asserts for 1 cycle, registered together with the level update, on the transition to LEVEL_MAX.
  - Re-arms only after level drops below LEVEL_MAX.
- drained:
  - Asserts for 1 cycle on the 1→0 level transition while drain_val_on=1.
  - If drain_val_on rises while level is already 0, drained pulses once, 1 cycle after the rising edge.
  - Re-arms when drain_val_on=0.
- Wash timer:
  - A qualifying cycle is motor_on=1 and drain_val_on=0.
  - The counter increments each qualifying cycle.
  - On the edge completing the WASH_CYC-th qualifying cycle, cycleTO pulses for 1 cycle and the counter disarms. There is no further pulse until motor_on returns to 0.
  - Non-qualifying cycles with motor_on=1 hold the count.
  - motor_on=0 clears the counter and re-arms the timer.
- Spin timer:
  - Same structure as the wash timer, with qualifying cycle motor_on=1 and drain_val_on=1, count SPIN_CYC, output spinTO.
  - A cycle with motor_on=1 qualifies for exactly one timer, so the two timers never count in the same cycle.
- Latency: with a timer condition first high in cycle 0 and held, the pulse is visible in cycle N, where N = WASH_CYC or SPIN_CYC.
- Simultaneous events: filled and cycleTO may pulse in the same cycle; the timers are independent of one another.

Optional Feature:
- Macro: WASH_PLANT_DOOR_PAUSE_EN.
- Defined:
  - While door_close=0, the level model and both timers freeze: counters, arm flags and level hold.
  - No filled, drained, cycleTO or spinTO pulse is generated while frozen.
  - Counting resumes from the held values on the first cycle door_close=1.
- Undefined: door_close has no effect on the level model or the timers.

Test Plan:
- Reset and debounce: reset=0 for 2 cycles, then release → all outputs 0. Then door_sw_raw=1 held → door_close=1 exactly 2+DEBOUNCE_CYC cycles later. A 2-cycle door_sw_raw=0 glitch → door_close stays 1.
- Fill and drain: fill_val_on=1 for 10 cycles → water_level 1..8, then saturates at 8; filled pulses once, in the cycle level=8. Then drain_val_on=1 → level 8→0, drained pulses once at 0, level stays 0 with no wrap. Both valves high together → level held.
- Wash timer: motor_on=1, drain_val_on=0 from cycle 0 → cycleTO=1 in cycle 16 only, with no repeat while motor_on stays high. motor_on dropped at cycle 10 and restarted → count restarts from 0.
- Spin timer with pause: motor_on=1, drain_val_on=1, with 3 cycles of drain_val_on=0 inserted mid-phase → the wash timer counts only those 3 cycles (no cycleTO), the spin count holds, and spinTO arrives 3 cycles later than cycle 8.
- Reset mid-phase: reset=0 at wash count 12, released while motor_on is held → no cycleTO for the aborted phase, level=0, and a new 16-cycle count starts after release.
- WASH_PLANT_DOOR_PAUSE_EN defined: door opened at wash count 5 for 20 cycles → count held at 5, no pulses; after door_close returns to 1, cycleTO fires 11 cycles later.

Source files
------------

// File: rtl/wash_plant_timer.sv
// wash_plant_timer: door debounce, drum level model and wash/spin phase timers feeding the washer controller.
// Define WASH_PLANT_DOOR_PAUSE_EN to freeze the level model and both timers while the door is open.
module wash_plant_timer #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int LEVEL_MAX    = 8,
    parameter int WASH_CYC     = 16,
    parameter int SPIN_CYC     = 8,
    parameter int CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           door_sw_raw,
    input  logic                           fill_val_on,
    input  logic                           drain_val_on,
    input  logic                           motor_on,
    output logic                           door_close,
    output logic                           filled,
    output logic                           drained,
    output logic                           cycleTO,
    output logic                           spinTO,
    output logic [$clog2(LEVEL_MAX+1)-1:0] water_level
);
    localparam int LVL_W = $clog2(LEVEL_MAX + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(LEVEL_MAX);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] WASH_LAST = CNT_W'(WASH_CYC - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_CYC - 1);

    logic             r_sync1, r_sync2, r_door_close;
    logic [DB_W-1:0]  r_db_cnt;
    logic [LVL_W-1:0] r_level;
    logic             r_filled, r_drained, r_drain_done;
    logic [CNT_W-1:0] r_wash_cnt, r_spin_cnt;
    logic             r_wash_done, r_spin_done, r_cycle_to, r_spin_to;

    logic             w_run, w_fill_only, w_drain_only;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_filled_ev, w_drained_ev;
    logic             w_wash_q, w_wash_hit, w_spin_q, w_spin_hit;
    logic [CNT_W-1:0] w_wash_cnt_nxt, w_spin_cnt_nxt;

`ifdef WASH_PLANT_DOOR_PAUSE_EN
    assign w_run = r_door_close;
`else
    assign w_run = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_db_cnt     <= '0;
            r_door_close <= 1'b0;
        end else begin
            r_sync1 <= door_sw_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_door_close)
                r_db_cnt <= '0;
            else if (r_db_cnt == DB_LAST) begin
                r_door_close <= r_sync2;
                r_db_cnt     <= '0;
            end else
                r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_fill_only  = fill_val_on && !drain_val_on;
    assign w_drain_only = drain_val_on && !fill_val_on;
    assign w_level_nxt  = (w_fill_only && r_level != LVL_FULL) ? r_level + 1'b1 :
                          (w_drain_only && r_level != '0) ? r_level - 1'b1 : r_level;
    assign w_filled_ev  = (w_level_nxt == LVL_FULL) && (r_level != LVL_FULL);
    // Also fires when drain opens on an already empty drum; r_drain_done blocks repeats until drain closes.
    assign w_drained_ev = drain_val_on && (w_level_nxt == '0) && !r_drain_done;

    assign w_wash_q       = motor_on && !drain_val_on && !r_wash_done;
    assign w_wash_hit     = w_wash_q && (r_wash_cnt == WASH_LAST);
    assign w_wash_cnt_nxt = (!motor_on || w_wash_hit) ? '0 : (w_wash_q ? r_wash_cnt + 1'b1 : r_wash_cnt);
    assign w_spin_q       = motor_on && drain_val_on && !r_spin_done;
    assign w_spin_hit     = w_spin_q && (r_spin_cnt == SPIN_LAST);
    assign w_spin_cnt_nxt = (!motor_on || w_spin_hit) ? '0 : (w_spin_q ? r_spin_cnt + 1'b1 : r_spin_cnt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_level      <= '0;
            r_filled     <= 1'b0;
            r_drained    <= 1'b0;
            r_drain_done <= 1'b0;
            r_wash_cnt   <= '0;
            r_wash_done  <= 1'b0;
            r_cycle_to   <= 1'b0;
            r_spin_cnt   <= '0;
            r_spin_done  <= 1'b0;
            r_spin_to    <= 1'b0;
        end else begin
            r_filled   <= w_run && w_filled_ev;
            r_drained  <= w_run && w_drained_ev;
            r_cycle_to <= w_run && w_wash_hit;
            r_spin_to  <= w_run && w_spin_hit;
            if (w_run) begin
                r_level      <= w_level_nxt;
                r_drain_done <= drain_val_on && (r_drain_done || w_drained_ev);
                r_wash_cnt   <= w_wash_cnt_nxt;
                r_wash_done  <= motor_on && (r_wash_done || w_wash_hit);
                r_spin_cnt   <= w_spin_cnt_nxt;
                r_spin_done  <= motor_on && (r_spin_done || w_spin_hit);
            end
        end
    end

    assign door_close  = r_door_close;
    assign filled      = r_filled;
    assign drained     = r_drained;
    assign cycleTO     = r_cycle_to;
    assign spinTO      = r_spin_to;
    assign water_level = r_level;
endmodule

// File: tb/tb_wash_plant_timer.sv
// tb_wash_plant_timer: vector table, hand-timed sequences and random stimulus against a cycle reference model.
module tb_wash_plant_timer;
    localparam int DEBOUNCE_CYC = 4;
    localparam int LEVEL_MAX    = 8;
    localparam int WASH_CYC     = 16;
    localparam int SPIN_CYC     = 8;
    localparam int CNT_W        = 16;
    localparam int LVL_W        = $clog2(LEVEL_MAX + 1);
`ifdef WASH_PLANT_DOOR_PAUSE_EN
    localparam int PAUSE = 1;
`else
    localparam int PAUSE = 0;
`endif

    logic clk = 1'b0;
    logic reset, door_sw_raw, fill_val_on, drain_val_on, motor_on;
    logic door_close, filled, drained, cycleTO, spinTO;
    logic [LVL_W-1:0] water_level;

    wash_plant_timer #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .LEVEL_MAX(LEVEL_MAX), .WASH_CYC(WASH_CYC),
        .SPIN_CYC(SPIN_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .door_sw_raw(door_sw_raw), .fill_val_on(fill_val_on),
        .drain_val_on(drain_val_on), .motor_on(motor_on), .door_close(door_close),
        .filled(filled), .drained(drained), .cycleTO(cycleTO), .spinTO(spinTO),
        .water_level(water_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mchk  = 0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Reference model: plain integers following the behavioural rules.
    int m_s1, m_s2, m_door, m_diff, m_lvl, m_dr_armed;
    int m_wash_n, m_wash_fired, m_spin_n, m_spin_fired;
    int m_filled, m_drained, m_cto, m_sto;

    task automatic model_edge();
        int nl;
        int run;
        m_filled = 0; m_drained = 0; m_cto = 0; m_sto = 0;
        if (!reset) begin
            m_s1 = 0; m_s2 = 0; m_door = 0; m_diff = 0; m_lvl = 0; m_dr_armed = 1;
            m_wash_n = 0; m_wash_fired = 0; m_spin_n = 0; m_spin_fired = 0;
            return;
        end
        run = PAUSE ? m_door : 1;
        if (run != 0) begin
            nl = m_lvl;
            if (fill_val_on && !drain_val_on && m_lvl < LEVEL_MAX) nl = m_lvl + 1;
            if (drain_val_on && !fill_val_on && m_lvl > 0) nl = m_lvl - 1;
            m_filled  = (nl == LEVEL_MAX && m_lvl != LEVEL_MAX) ? 1 : 0;
            m_drained = (drain_val_on && nl == 0 && m_dr_armed != 0) ? 1 : 0;
            if (!drain_val_on) m_dr_armed = 1;
            else if (m_drained != 0) m_dr_armed = 0;
            m_lvl = nl;
            if (!motor_on) begin
                m_wash_n = 0; m_wash_fired = 0; m_spin_n = 0; m_spin_fired = 0;
            end else if (!drain_val_on) begin
                if (m_wash_fired == 0) begin
                    m_wash_n++;
                    if (m_wash_n == WASH_CYC) begin m_cto = 1; m_wash_fired = 1; end
                end
            end else if (m_spin_fired == 0) begin
                m_spin_n++;
                if (m_spin_n == SPIN_CYC) begin m_sto = 1; m_spin_fired = 1; end
            end
        end
        if (m_s2 != m_door) begin
            m_diff++;
            if (m_diff >= DEBOUNCE_CYC) begin m_door = m_s2; m_diff = 0; end
        end else m_diff = 0;
        m_s2 = m_s1;
        m_s1 = door_sw_raw ? 1 : 0;
    endtask

    always @(posedge clk) model_edge();

    task automatic tick();
        @(negedge clk);
        if (mchk) begin
            chk("mdl_door", int'(door_close), m_door);
            chk("mdl_level", int'(water_level), m_lvl);
            chk("mdl_filled", int'(filled), m_filled);
            chk("mdl_drained", int'(drained), m_drained);
            chk("mdl_cycleTO", int'(cycleTO), m_cto);
            chk("mdl_spinTO", int'(spinTO), m_sto);
        end
    endtask

    typedef struct { int fill; int drain; int lvl; int fp; int dp; } vec_t;
    vec_t tbl[$];

    function automatic void add(int f, int d, int l, int fp, int dp);
        tbl.push_back('{f, d, l, fp, dp});
    endfunction

    initial begin
        int exp_p;
        for (int i = 1; i <= 10; i++) add(1, 0, (i < 8) ? i : 8, (i == 8) ? 1 : 0, 0);
        for (int i = 1; i <= 10; i++) add(0, 1, (i < 8) ? 8 - i : 0, 0, (i == 8) ? 1 : 0);
        add(1, 0, 1, 0, 0); add(1, 0, 2, 0, 0); add(1, 0, 3, 0, 0);
        add(1, 1, 3, 0, 0); add(1, 1, 3, 0, 0); add(1, 1, 3, 0, 0); add(0, 0, 3, 0, 0);
        add(0, 1, 2, 0, 0); add(0, 1, 1, 0, 0); add(0, 1, 0, 0, 1); add(0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1); add(0, 1, 0, 0, 0); add(0, 0, 0, 0, 0);

        reset = 1'b0; door_sw_raw = 1'b0; fill_val_on = 1'b0; drain_val_on = 1'b0; motor_on = 1'b0;
        tick(); tick();
        mchk = 1;
        reset = 1'b1;
        tick();
        chk("rst_door", int'(door_close), 0);
        chk("rst_level", int'(water_level), 0);
        chk("rst_pulses", int'({filled, drained, cycleTO, spinTO}), 0);

        door_sw_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("door_rise[%0d]", k), int'(door_close), (k == 6) ? 1 : 0);
        end
        door_sw_raw = 1'b0;
        tick(); tick();
        door_sw_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("glitch[%0d]", k), int'(door_close), 1);
        end

        foreach (tbl[i]) begin
            fill_val_on  = (tbl[i].fill != 0);
            drain_val_on = (tbl[i].drain != 0);
            tick();
            chk($sformatf("tbl_level[%0d]", i), int'(water_level), tbl[i].lvl);
            chk($sformatf("tbl_filled[%0d]", i), int'(filled), tbl[i].fp);
            chk($sformatf("tbl_drained[%0d]", i), int'(drained), tbl[i].dp);
            chk($sformatf("tbl_timers[%0d]", i), int'({cycleTO, spinTO}), 0);
        end

        fill_val_on = 1'b0; drain_val_on = 1'b0; motor_on = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk($sformatf("wash[%0d]", k), int'(cycleTO), (k == 16) ? 1 : 0);
        end
        motor_on = 1'b0; tick();
        motor_on = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("wash_part[%0d]", k), int'(cycleTO), 0);
        end
        motor_on = 1'b0; tick();
        motor_on = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("wash_restart[%0d]", k), int'(cycleTO), (k == 16) ? 1 : 0);
        end

        motor_on = 1'b0; tick();
        motor_on = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            drain_val_on = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("spin[%0d]", k), int'(spinTO), (k == 11) ? 1 : 0);
            chk($sformatf("spin_wash[%0d]", k), int'(cycleTO), 0);
        end

        drain_val_on = 1'b0; motor_on = 1'b0; tick();
        motor_on = 1'b1; fill_val_on = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("pre_rst[%0d]", k), int'(cycleTO), 0);
        end
        reset = 1'b0; fill_val_on = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk($sformatf("in_rst_level[%0d]", k), int'(water_level), 0);
            chk($sformatf("in_rst_cto[%0d]", k), int'(cycleTO), 0);
            chk($sformatf("in_rst_door[%0d]", k), int'(door_close), 0);
        end
        reset = 1'b1;
        exp_p = PAUSE ? DEBOUNCE_CYC + 2 + WASH_CYC : WASH_CYC;
        for (int p = 1; p <= 24; p++) begin
            tick();
            chk($sformatf("post_rst_cto[%0d]", p), int'(cycleTO), (p == exp_p) ? 1 : 0);
            if (p == 1) chk("post_rst_level", int'(water_level), 0);
        end

`ifdef WASH_PLANT_DOOR_PAUSE_EN
        motor_on = 1'b0; tick();
        door_sw_raw = 1'b0; tick();
        motor_on = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk($sformatf("pause_door_fall[%0d]", k), int'(door_close), (k < 6) ? 1 : 0);
        end
        for (int k = 7; k <= 20; k++) begin
            tick();
            chk($sformatf("pause_hold[%0d]", k), int'({cycleTO, door_close}), 0);
        end
        door_sw_raw = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            tick();
            chk($sformatf("pause_door[%0d]", j), int'(door_close), (j >= 6) ? 1 : 0);
            chk($sformatf("pause_cto[%0d]", j), int'(cycleTO), (j == 17) ? 1 : 0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) fill_val_on = ~fill_val_on;
            if ($urandom_range(0, 9) == 0) drain_val_on = ~drain_val_on;
            if ($urandom_range(0, 29) == 0) motor_on = ~motor_on;
            if ($urandom_range(0, 59) == 0) door_sw_raw = ~door_sw_raw;
            reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
